// File: rtl/common_dffcam_1a1w1r_nq_alloc.sv
// ---------------------------------------------------------------------------
// common_dffcam_1a1w1r_nq_alloc
//
// Flip-flop CAM with one addressed read/write port, QUERY_PORTS parallel
// match ports and an allocate-on-insert port that chooses its own victim
// (lowest free entry, else round-robin once the CAM is full).
//
// Ports
//   clk, resetn            clock / asynchronous active-low reset
//   addr, en, we           addressed port: entry index, enable, write(1)/read(0)
//   din, din_valid         addressed write data and valid bit
//   dout, dout_valid       registered read data and valid bit (1-cycle latency)
//   qdata                  query keys, port i at [i*CAM_WIDTH +: CAM_WIDTH]
//   qaddr, qvalid, qmulti  per-port lowest match index, hit, multi-hit
//   alloc_en, alloc_data   insert request and data (stored valid)
//   alloc_ready            insert accepted this cycle
//   alloc_done, alloc_addr registered pulse and index of the last insert
//   full                   every entry valid
//   flush                  synchronous invalidate-all
// ---------------------------------------------------------------------------
module common_dffcam_1a1w1r_nq_alloc #(
  parameter int CAM_WIDTH            = 32,
  parameter int CAM_DEPTH            = 32,
  parameter int QUERY_PORTS          = 2,
  parameter int QUERY_REGISTERED     = 0,
  parameter int CAM_ADDRESS_ONEHOT   = 0,
  parameter int QUERY_ADDRESS_ONEHOT = 0,
  localparam int IW  = $clog2(CAM_DEPTH),
  localparam int AW  = (CAM_ADDRESS_ONEHOT != 0) ? CAM_DEPTH : IW,
  localparam int QAW = (QUERY_ADDRESS_ONEHOT != 0) ? CAM_DEPTH : IW
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [AW-1:0]                    addr,
  input  logic                             en,
  input  logic                             we,
  input  logic [CAM_WIDTH-1:0]             din,
  input  logic                             din_valid,
  output logic [CAM_WIDTH-1:0]             dout,
  output logic                             dout_valid,
  input  logic [QUERY_PORTS*CAM_WIDTH-1:0] qdata,
  output logic [QUERY_PORTS*QAW-1:0]       qaddr,
  output logic [QUERY_PORTS-1:0]           qvalid,
  output logic [QUERY_PORTS-1:0]           qmulti,
  input  logic                             alloc_en,
  input  logic [CAM_WIDTH-1:0]             alloc_data,
  output logic                             alloc_ready,
  output logic                             alloc_done,
  output logic [AW-1:0]                    alloc_addr,
  output logic                             full,
  input  logic                             flush
);

  logic [CAM_WIDTH-1:0] data_q [CAM_DEPTH];
  logic [CAM_DEPTH-1:0] valid_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [CAM_WIDTH-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 alloc_done_q;
  logic [AW-1:0]        alloc_addr_q;

  // Addressed-port decode: one select bit per entry, all zero for an
  // illegal address so writes drop and reads return 0/0 naturally.
  logic [CAM_DEPTH-1:0] addr_sel;
  if (CAM_ADDRESS_ONEHOT != 0) begin : g_addr_oh
    logic addr_ok;
    assign addr_ok  = (addr != '0) && ((addr & (addr - AW'(1))) == '0);
    assign addr_sel = addr_ok ? addr : '0;
  end else begin : g_addr_bin
    always_comb begin
      for (int k = 0; k < CAM_DEPTH; k++) addr_sel[k] = (addr == AW'(k));
    end
  end

  logic [CAM_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional update, otherwise the unassigned paths infer latches.
  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    for (int k = 0; k < CAM_DEPTH; k++) begin
      if (addr_sel[k]) begin
        rd_data  = rd_data | data_q[k];
        rd_valid = rd_valid | valid_q[k];
      end
    end
  end

  // Victim selection: lowest free entry, or the round-robin pointer once full.
  logic [IW-1:0] free_idx;
  logic [IW-1:0] victim_idx;
  logic [IW-1:0] rr_next;
  logic [AW-1:0] victim_enc;
  logic          alloc_fire;

  assign full = &valid_q;

  always_comb begin
    free_idx = '0;
    for (int k = CAM_DEPTH - 1; k >= 0; k--) begin
      if (!valid_q[k]) free_idx = IW'(k);
    end
  end

  assign victim_idx  = full ? rr_ptr_q : free_idx;
  assign rr_next     = (rr_ptr_q == IW'(CAM_DEPTH - 1)) ? '0 : rr_ptr_q + IW'(1);
  assign alloc_ready = !(en && we) && !flush;
  assign alloc_fire  = alloc_en && alloc_ready;

  if (CAM_ADDRESS_ONEHOT != 0) begin : g_victim_oh
    assign victim_enc = AW'(1) << victim_idx;
  end else begin : g_victim_bin
    assign victim_enc = victim_idx;
  end

  // NOTE: stored data is cleared on reset as well as the valid bits, so a
  // read of any entry right after reset returns zeros, not stale contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
      for (int k = 0; k < CAM_DEPTH; k++) data_q[k] <= '0;
    end else if (flush) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      // An addressed write and an allocation never coexist: the write
      // deasserts alloc_ready.
      for (int k = 0; k < CAM_DEPTH; k++) begin
        if (en && we && addr_sel[k]) begin
          data_q[k]  <= din;
          valid_q[k] <= din_valid;
        end else if (alloc_fire && (victim_idx == IW'(k))) begin
          data_q[k]  <= alloc_data;
          valid_q[k] <= 1'b1;
        end
      end
      if (alloc_fire && full) rr_ptr_q <= rr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a read of the allocation victim gets old data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      alloc_done_q <= 1'b0;
      alloc_addr_q <= '0;
    end else begin
      if (en && !we) begin
        dout_q       <= rd_data;
        dout_valid_q <= rd_valid;
      end
      alloc_done_q <= alloc_fire;
      if (alloc_fire) alloc_addr_q <= victim_enc;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign alloc_done = alloc_done_q;
  assign alloc_addr = alloc_addr_q;

  // Query ports: match vector per port, then lowest-index encode.
  logic [QUERY_PORTS-1:0]     hit_c;
  logic [QUERY_PORTS-1:0]     multi_c;
  logic [QUERY_PORTS*QAW-1:0] qaddr_c;

  for (genvar p = 0; p < QUERY_PORTS; p++) begin : g_query
    logic [CAM_DEPTH-1:0] match;
    always_comb begin
      for (int k = 0; k < CAM_DEPTH; k++) begin
        match[k] = valid_q[k] && (data_q[k] == qdata[p*CAM_WIDTH +: CAM_WIDTH]);
      end
    end
    assign hit_c[p]   = |match;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_c[p] = |(match & (match - CAM_DEPTH'(1)));
    if (QUERY_ADDRESS_ONEHOT != 0) begin : g_qoh
      assign qaddr_c[p*QAW +: QAW] = match & (~match + CAM_DEPTH'(1));
    end else begin : g_qbin
      logic [QAW-1:0] idx;
      always_comb begin
        idx = '0;
        for (int k = CAM_DEPTH - 1; k >= 0; k--) begin
          if (match[k]) idx = QAW'(k);
        end
      end
      assign qaddr_c[p*QAW +: QAW] = idx;
    end
  end

  if (QUERY_REGISTERED != 0) begin : g_qreg
    logic [QUERY_PORTS-1:0]     qvalid_q;
    logic [QUERY_PORTS-1:0]     qmulti_q;
    logic [QUERY_PORTS*QAW-1:0] qaddr_q;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        qvalid_q <= '0;
        qmulti_q <= '0;
        qaddr_q  <= '0;
      end else begin
        qvalid_q <= hit_c;
        qmulti_q <= multi_c;
        qaddr_q  <= qaddr_c;
      end
    end
    assign qvalid = qvalid_q;
    assign qmulti = qmulti_q;
    assign qaddr  = qaddr_q;
  end else begin : g_qcomb
    assign qvalid = hit_c;
    assign qmulti = multi_c;
    assign qaddr  = qaddr_c;
  end

endmodule

// File: tb/tb_common_dffcam_1a1w1r_nq_alloc.sv
module tb_common_dffcam_1a1w1r_nq_alloc;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: defaults (binary, combinational query) ----
  logic        rstn_a;
  logic [4:0]  addr;
  logic        en, we, din_valid, alloc_en, flush;
  logic [31:0] din, alloc_data;
  logic [63:0] qdata;
  logic [31:0] dout;
  logic        dout_valid, alloc_ready, alloc_done, full;
  logic [9:0]  qaddr;
  logic [1:0]  qvalid, qmulti;
  logic [4:0]  alloc_addr;

  common_dffcam_1a1w1r_nq_alloc dut_a (
    .clk(clk), .resetn(rstn_a), .addr(addr), .en(en), .we(we), .din(din),
    .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid), .qdata(qdata),
    .qaddr(qaddr), .qvalid(qvalid), .qmulti(qmulti), .alloc_en(alloc_en),
    .alloc_data(alloc_data), .alloc_ready(alloc_ready), .alloc_done(alloc_done),
    .alloc_addr(alloc_addr), .full(full), .flush(flush)
  );

  // ---------------- instance B: one-hot addressing, registered query -------
  logic        rstn_b;
  logic [7:0]  b_addr;
  logic        b_en, b_we, b_din_valid, b_alloc_en, b_flush;
  logic [31:0] b_din, b_alloc_data, b_qdata;
  logic [31:0] b_dout;
  logic        b_dout_valid, b_alloc_ready, b_alloc_done, b_full;
  logic [7:0]  b_qaddr;
  logic [0:0]  b_qvalid, b_qmulti;
  logic [7:0]  b_alloc_addr;

  common_dffcam_1a1w1r_nq_alloc #(
    .CAM_WIDTH(32), .CAM_DEPTH(8), .QUERY_PORTS(1), .QUERY_REGISTERED(1),
    .CAM_ADDRESS_ONEHOT(1), .QUERY_ADDRESS_ONEHOT(1)
  ) dut_b (
    .clk(clk), .resetn(rstn_b), .addr(b_addr), .en(b_en), .we(b_we), .din(b_din),
    .din_valid(b_din_valid), .dout(b_dout), .dout_valid(b_dout_valid), .qdata(b_qdata),
    .qaddr(b_qaddr), .qvalid(b_qvalid), .qmulti(b_qmulti), .alloc_en(b_alloc_en),
    .alloc_data(b_alloc_data), .alloc_ready(b_alloc_ready), .alloc_done(b_alloc_done),
    .alloc_addr(b_alloc_addr), .full(b_full), .flush(b_flush)
  );

  // ---------------- reference model for instance A -------------------------
  logic [31:0] m_data [DEPTH];
  bit          m_valid [DEPTH];
  int          m_rr;
  logic [31:0] e_dout;
  bit          e_dout_valid;
  bit          e_done;
  logic [4:0]  e_alloc_addr;

  function automatic bit m_full();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_valid[k]);
    return n == DEPTH;
  endfunction

  task automatic m_query(input logic [31:0] key, output bit hit, output int idx, output int cnt);
    cnt = 0;
    idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (m_valid[k] && m_data[k] == key) begin
        if (cnt == 0) idx = k;
        cnt++;
      end
    end
    hit = (cnt > 0);
  endtask

  // Advance the model by one clock using the inputs currently driven on A.
  task automatic model_clock();
    int  victim;
    bit  found;
    if (en && !we) begin
      e_dout       = m_data[addr];
      e_dout_valid = m_valid[addr];
    end
    e_done = alloc_en && !(en && we) && !flush;
    victim = 0;
    if (e_done) begin
      found = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && !m_valid[k]) begin
          victim = k;
          found  = 1;
        end
      end
      if (!found) begin
        victim = m_rr;
        m_rr   = (m_rr + 1) % DEPTH;
      end
      e_alloc_addr = 5'(victim);
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
      m_rr = 0;
    end else if (en && we) begin
      m_data[addr]  = din;
      m_valid[addr] = din_valid;
    end else if (e_done) begin
      m_data[victim]  = alloc_data;
      m_valid[victim] = 1;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    en = 0; we = 0; addr = '0; din = '0; din_valid = 0;
    alloc_en = 0; alloc_data = '0; flush = 0; qdata = '0;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %0b want 0", dout_valid); end
    checks++; if (alloc_done !== 1'b0) begin errors++; $display("FAIL reset_alloc_done: got %0b want 0", alloc_done); end
    checks++; if (alloc_addr !== 5'd0) begin errors++; $display("FAIL reset_alloc_addr: got %0d want 0", alloc_addr); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
    checks++; if (qvalid !== 2'b00 || qaddr !== 10'd0 || qmulti !== 2'b00) begin
      errors++; $display("FAIL reset_query: qvalid %0b qaddr %0h qmulti %0b want 0/0/0", qvalid, qaddr, qmulti);
    end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b want 1", alloc_ready); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      alloc_en = 1; alloc_data = 32'h100 + k;
      #1;
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %0b want 1", k, alloc_ready); end
      tick();
      checks++; if (alloc_done !== 1'b1 || alloc_addr !== 5'(k)) begin
        errors++; $display("FAIL fill_addr[%0d]: done %0b addr %0d want 1 %0d", k, alloc_done, alloc_addr, k);
      end
    end
    idle_a();
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b want 1", full); end
    tick();
    checks++; if (alloc_done !== 1'b0) begin errors++; $display("FAIL fill_done_drop: got %0b want 0", alloc_done); end
  endtask

  task automatic test_full_round_robin();
    logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      alloc_en = 1; alloc_data = vals[i];
      tick();
      checks++; if (alloc_done !== 1'b1 || alloc_addr !== 5'(i)) begin
        errors++; $display("FAIL rr_victim[%0d]: done %0b addr %0d want 1 %0d", i, alloc_done, alloc_addr, i);
      end
    end
    idle_a();
    qdata = {32'hB, 32'h100};
    #1;
    checks++; if (qvalid !== 2'b10 || qaddr !== {5'd1, 5'd0} || qmulti !== 2'b00) begin
      errors++; $display("FAIL rr_query: qvalid %0b qaddr %0h qmulti %0b want 10 %0h 00", qvalid, qaddr, {5'd1, 5'd0}, qmulti);
    end
  endtask

  task automatic test_multi_hit();
    en = 1; we = 1; din = 32'hDEAD; din_valid = 1;
    addr = 5'd5; tick();
    addr = 5'd9; tick();
    idle_a();
    qdata = {32'hDEAD, 32'hDEAD};
    #1;
    checks++; if (qvalid !== 2'b11 || qaddr !== {5'd5, 5'd5} || qmulti !== 2'b11) begin
      errors++; $display("FAIL multi_hit: qvalid %0b qaddr %0h qmulti %0b want 11 %0h 11", qvalid, qaddr, {5'd5, 5'd5}, qmulti);
    end
  endtask

  task automatic test_write_blocks_alloc();
    en = 1; we = 1; addr = 5'd3; din = 32'h3333; din_valid = 1;
    alloc_en = 1; alloc_data = 32'h4444;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL blk_ready: got %0b want 0", alloc_ready); end
    tick();
    checks++; if (alloc_done !== 1'b0) begin errors++; $display("FAIL blk_done: got %0b want 0", alloc_done); end
    en = 0; we = 0;
    qdata = {32'h0, 32'h3333};
    #1;
    checks++; if (qvalid[0] !== 1'b1 || qaddr[4:0] !== 5'd3) begin
      errors++; $display("FAIL blk_written: qvalid %0b qaddr %0d want 1 3", qvalid[0], qaddr[4:0]);
    end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL blk_ready2: got %0b want 1", alloc_ready); end
    tick();
    checks++; if (alloc_done !== 1'b1 || alloc_addr !== 5'd3) begin
      errors++; $display("FAIL blk_retry: done %0b addr %0d want 1 3", alloc_done, alloc_addr);
    end
    idle_a();
  endtask

  task automatic test_flush();
    flush = 1; en = 1; we = 1; addr = 5'd7; din = 32'h7777; din_valid = 1;
    alloc_en = 1; alloc_data = 32'h4545;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", alloc_ready); end
    tick();
    checks++; if (alloc_done !== 1'b0) begin errors++; $display("FAIL flush_done: got %0b want 0", alloc_done); end
    idle_a();
    qdata = {32'h4444, 32'h7777};
    #1;
    checks++; if (qvalid !== 2'b00 || full !== 1'b0) begin
      errors++; $display("FAIL flush_state: qvalid %0b full %0b want 00 0", qvalid, full);
    end
    en = 1; we = 0; addr = 5'd7;
    tick();
    checks++; if (dout !== 32'h107 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL flush_entry7: dout %0h valid %0b want 107 0", dout, dout_valid);
    end
    idle_a();
    alloc_en = 1; alloc_data = 32'h55;
    tick();
    checks++; if (alloc_done !== 1'b1 || alloc_addr !== 5'd0) begin
      errors++; $display("FAIL flush_realloc: done %0b addr %0d want 1 0", alloc_done, alloc_addr);
    end
    idle_a();
  endtask

  task automatic test_read_victim();
    alloc_en = 1; alloc_data = 32'h66; en = 1; we = 0; addr = 5'd1;
    tick();
    checks++; if (dout !== 32'hB || dout_valid !== 1'b0 || alloc_addr !== 5'd1) begin
      errors++; $display("FAIL victim_read: dout %0h valid %0b addr %0d want b 0 1", dout, dout_valid, alloc_addr);
    end
    idle_a();
    flush = 1; en = 1; we = 0; addr = 5'd1;
    tick();
    checks++; if (dout !== 32'h66 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL flush_read: dout %0h valid %0b want 66 1", dout, dout_valid);
    end
    idle_a();
  endtask

  task automatic test_random();
    bit hit;
    int idx, cnt;
    for (int c = 0; c < 400; c++) begin
      en         = ($urandom_range(0, 2) == 0);
      we         = $urandom_range(0, 1) == 1;
      addr       = 5'($urandom_range(0, DEPTH - 1));
      din        = 32'($urandom_range(0, 15));
      din_valid  = ($urandom_range(0, 3) != 0);
      alloc_en   = $urandom_range(0, 1) == 1;
      alloc_data = 32'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 39) == 0);
      qdata      = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15))};
      #1;
      for (int p = 0; p < 2; p++) begin
        m_query(qdata[p*32 +: 32], hit, idx, cnt);
        checks++;
        if (qvalid[p] !== hit || qaddr[p*5 +: 5] !== 5'(idx) || qmulti[p] !== (cnt >= 2)) begin
          errors++;
          $display("FAIL rnd_query c%0d p%0d: qvalid %0b qaddr %0d qmulti %0b want %0b %0d %0b",
                   c, p, qvalid[p], qaddr[p*5 +: 5], qmulti[p], hit, idx, cnt >= 2);
        end
      end
      checks++; if (full !== m_full() || alloc_ready !== (!(en && we) && !flush)) begin
        errors++; $display("FAIL rnd_comb c%0d: full %0b ready %0b want %0b %0b", c, full, alloc_ready, m_full(), !(en && we) && !flush);
      end
      tick();
      checks++;
      if (dout !== e_dout || dout_valid !== e_dout_valid || alloc_done !== e_done || alloc_addr !== e_alloc_addr) begin
        errors++;
        $display("FAIL rnd_regs c%0d: dout %0h/%0b done %0b addr %0d want %0h/%0b %0b %0d",
                 c, dout, dout_valid, alloc_done, alloc_addr, e_dout, e_dout_valid, e_done, e_alloc_addr);
      end
    end
    idle_a();
  endtask

  task automatic test_onehot_addr();
    b_en = 1; b_we = 1; b_addr = 8'b0000_0100; b_din = 32'h22; b_din_valid = 1;
    tick_b();
    b_we = 0;
    tick_b();
    checks++; if (b_dout !== 32'h22 || b_dout_valid !== 1'b1) begin
      errors++; $display("FAIL oh_read2: dout %0h valid %0b want 22 1", b_dout, b_dout_valid);
    end
    b_addr = 8'b0;
    tick_b();
    checks++; if (b_dout !== 32'h0 || b_dout_valid !== 1'b0) begin
      errors++; $display("FAIL oh_read_zero: dout %0h valid %0b want 0 0", b_dout, b_dout_valid);
    end
    b_addr = 8'b0000_0100;
    tick_b();
    b_addr = 8'b0000_0110;
    tick_b();
    checks++; if (b_dout !== 32'h0 || b_dout_valid !== 1'b0) begin
      errors++; $display("FAIL oh_read_multi: dout %0h valid %0b want 0 0", b_dout, b_dout_valid);
    end
    b_we = 1; b_din = 32'h99;
    tick_b();
    b_en = 0; b_we = 0;
    b_qdata = 32'h99;
    tick_b();
    checks++; if (b_qvalid !== 1'b0) begin errors++; $display("FAIL oh_write_dropped: qvalid %0b want 0", b_qvalid); end
    b_qdata = 32'h22;
    #1;
    checks++; if (b_qvalid !== 1'b0) begin errors++; $display("FAIL oh_qreg_latency: qvalid %0b want 0", b_qvalid); end
    tick_b();
    checks++; if (b_qvalid !== 1'b1 || b_qaddr !== 8'b0000_0100 || b_qmulti !== 1'b0) begin
      errors++; $display("FAIL oh_qreg_hit: qvalid %0b qaddr %0h qmulti %0b want 1 4 0", b_qvalid, b_qaddr, b_qmulti);
    end
  endtask

  task automatic test_reset_mid_alloc();
    b_alloc_en = 1; b_alloc_data = 32'h55;
    tick_b();
    checks++; if (b_alloc_done !== 1'b1 || b_alloc_addr !== 8'b0000_0001) begin
      errors++; $display("FAIL rst_pre_alloc: done %0b addr %0h want 1 1", b_alloc_done, b_alloc_addr);
    end
    rstn_b = 0;
    #1;
    checks++; if (b_alloc_done !== 1'b0 || b_alloc_addr !== 8'h0 || b_full !== 1'b0 || b_dout_valid !== 1'b0 || b_qvalid !== 1'b0) begin
      errors++; $display("FAIL rst_async: done %0b addr %0h full %0b dvalid %0b qvalid %0b want all 0",
                         b_alloc_done, b_alloc_addr, b_full, b_dout_valid, b_qvalid);
    end
    @(posedge clk); #1;
    rstn_b = 1; b_alloc_en = 0; b_qdata = 32'h22;
    tick_b();
    checks++; if (b_qvalid !== 1'b0 || b_alloc_done !== 1'b0) begin
      errors++; $display("FAIL rst_cleared: qvalid %0b done %0b want 0 0", b_qvalid, b_alloc_done);
    end
  endtask

  initial begin
    rstn_a = 0; rstn_b = 0;
    idle_a();
    b_en = 0; b_we = 0; b_addr = '0; b_din = '0; b_din_valid = 0;
    b_alloc_en = 0; b_alloc_data = '0; b_flush = 0; b_qdata = '0;
    for (int k = 0; k < DEPTH; k++) begin m_data[k] = '0; m_valid[k] = 0; end
    m_rr = 0; e_dout = '0; e_dout_valid = 0; e_done = 0; e_alloc_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rstn_a = 1; rstn_b = 1;
    test_fill();
    test_full_round_robin();
    test_multi_hit();
    test_write_blocks_alloc();
    test_flush();
    test_read_victim();
    test_random();
    test_onehot_addr();
    test_reset_mid_alloc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/common_dffcam_1a1w1r_nq_alloc.md
Name: common_dffcam_1a1w1r_nq_alloc

Overview:
- Flip-flop CAM with one addressed read/write port, QUERY_PORTS parallel match ports, and an allocate-on-insert port.
- The allocate port picks a victim entry itself: first free entry, else round-robin.
- Generalises the single-query DFF CAM used by the TLB/tag structures.
- Adds multi-port lookup, optional registered query, multi-hit detection, allocation and flush.

Parameters:
- CAM_WIDTH, 32, entry data width.
- CAM_DEPTH, 32, number of entries (>=2, any value, not only powers of two).
- QUERY_PORTS, 2, number of independent query ports (>=1).
- QUERY_REGISTERED, 0, 0 = combinational query result; 1 = one-cycle registered result.
- CAM_ADDRESS_ONEHOT, 0, 1 = addr/alloc_addr are one-hot of CAM_DEPTH bits; 0 = binary of AW = clog2(CAM_DEPTH) bits.
- QUERY_ADDRESS_ONEHOT, 0, same encoding choice for qaddr (width QAW).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- addr  in  AW  addressed-port entry index.
- en  in  1  addressed-port enable.
- we  in  1  write (1) / read (0) when en.
- din  in  CAM_WIDTH  write data.
- din_valid  in  1  valid bit written with din.
- dout  out  CAM_WIDTH  registered read data.
- dout_valid  out  1  registered read valid bit.
- qdata  in  QUERY_PORTS*CAM_WIDTH  query keys; port i occupies bits [i*W +: W].
- qaddr  out  QUERY_PORTS*QAW  matching index per port.
- qvalid  out  QUERY_PORTS  hit per port.
- qmulti  out  QUERY_PORTS  more than one valid entry matched.
- alloc_en  in  1  insert alloc_data into a victim entry.
- alloc_data  in  CAM_WIDTH  data to insert (valid bit set to 1).
- alloc_ready  out  1  allocation accepted this cycle; equals !(en & we) & !flush.
- alloc_done  out  1  registered pulse: an allocation was performed last cycle.
- alloc_addr  out  AW  registered index written by that allocation.
- full  out  1  all entries valid (combinational from state).
- flush  in  1  synchronous invalidate-all.

Behaviour:
- Reset (resetn low, async):
  - All valid bits and data are cleared to 0; rr_ptr = 0.
  - dout = 0, dout_valid = 0, alloc_done = 0, alloc_addr = 0.
  - If QUERY_REGISTERED = 1, the registered qvalid, qmulti and qaddr are also 0.
  - Deassertion takes effect at the next edge; any operation in flight during reset is lost.
- Addressed write: en & we writes din/din_valid into entry addr at the edge.
- Addressed read: en & !we loads dout/dout_valid from entry addr at the edge (1-cycle latency). dout holds its value when there is no read.
- Invalid one-hot address (zero or multiple bits set):
  - A write is dropped.
  - A read returns dout = 0, dout_valid = 0.
- Binary addr >= CAM_DEPTH: treated the same way (write dropped, read returns 0/0).
- Query match: per port, an entry matches when its valid bit is 1 and its data == qdata_i.
  - qvalid_i = any entry matched.
  - qaddr_i = lowest matching index; 0 when there is no hit.
  - qmulti_i = two or more entries matched.
- Query timing: queries observe state before the current edge. A same-cycle write or allocation is not visible until the next cycle.
- QUERY_REGISTERED = 1: the query result is captured at the edge and presented one cycle later. The captured result reflects state before that edge.
- Allocation (alloc_en & alloc_ready):
  - Victim = lowest-index invalid entry if !full; otherwise victim = rr_ptr.
  - rr_ptr advances (wrapping CAM_DEPTH-1 to 0) only when the victim was taken from rr_ptr.
  - The entry is written with alloc_data and valid = 1.
  - Next cycle: alloc_done = 1 and alloc_addr = victim; otherwise alloc_done = 0 and alloc_addr holds.
- Conflicts:
  - An addressed write blocks allocation (alloc_ready = 0). The requester must hold alloc_en.
  - An addressed read does not block allocation; if the read targets the victim entry, it returns the old contents.
- Flush: clears all valid bits and sets rr_ptr = 0 at the edge. It overrides a same-cycle addressed write and allocation (both dropped; alloc_ready = 0). A same-cycle read still returns pre-flush contents.
- Duplicate data is not checked on write or allocate; duplicates are reported through qmulti.

Test Plan:
1. Reset, then fill every entry with alloc_en, alloc_data = 0x100+k → alloc_addr = 0,1,..,31 in order; full = 1 after the 32nd allocation; rr_ptr still 0.
2. With the CAM full, issue 3 more allocations (0xA, 0xB, 0xC) → victims 0, 1, 2; querying 0x100 misses; querying 0xB on port 1 gives qvalid = 1, qaddr = 1.
3. Write entries 5 and 9 = 0xDEAD (valid) via the addressed port; query 0xDEAD on both ports → qvalid = 1, qaddr = 5, qmulti = 1; with QUERY_REGISTERED = 1 the result appears one cycle later.
4. Same-cycle en & we (addr 3) with alloc_en → alloc_ready = 0, entry 3 written, no alloc_done; the held alloc_en completes the next cycle.
5. Flush together with a write to addr 7 and an allocation → all qvalid = 0 next cycle, full = 0, entry 7 invalid, the following allocation goes to entry 0.
6. CAM_ADDRESS_ONEHOT = 1: read with addr = 0 or 0b0110 → dout = 0, dout_valid = 0; write with 0b0110 → no entry changes. Also assert resetn low mid-allocation → alloc_done = 0 immediately and all entries invalid.
